mpu_store_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single matrix store engine among NREQ requesters (CPU front-end, MPU result writeback, debug port, and so on).
- Picks one requester and drives the engine's store enable and register address.
- Holds the enable until the engine finishes streaming the matrix out.
- Reports per-requester completion, or an error on timeout.
- Sits between the requester interfaces and the store engine's store_en_in / mem_store_addr_in inputs.

---
 rtl/global_defs.sv | 4 +
 rtl/mpu_pkg.sv | 13 +
 rtl/mpu_store_arbiter_rr_pick.sv | 30 +++
 rtl/mpu_store_arbiter.sv | 151 +++++++++++++++
 tb/tb_mpu_store_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/global_defs.sv
// Project-wide sizing constants shared by the matrix datapath blocks.
package global_defs;
    localparam int MATRIX_REG_BITS = 3;
endpackage

// File: rtl/mpu_pkg.sv
// Shared types and default sizes for the MPU request arbiters.
package mpu_pkg;
    localparam int STORE_ARB_NREQ    = 4;
    localparam int STORE_ARB_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_START,
        ARB_BUSY,
        ARB_DONE,
        ARB_ERR
    } arb_state_t;
endpackage

// File: rtl/mpu_store_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, with wrap.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic            found_o,
    output logic [PW-1:0]   idx_o
);
    localparam int CW = PW + 1;

    logic [CW-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_i} + CW'(k);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!found_o && req_i[cand[PW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/mpu_store_arbiter.sv
// Shares the matrix store engine among NREQ requesters; holds store enable until streaming ends.
// States: IDLE arbitrate | START wait engine | BUSY streaming | DONE done pulse | ERR timeout pulse
module mpu_store_arbiter
    import mpu_pkg::*;
    import global_defs::*;
#(
    parameter int NREQ    = STORE_ARB_NREQ,
    parameter int TIMEOUT = STORE_ARB_TIMEOUT,
    parameter int TBITS   = $clog2(TIMEOUT + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NREQ-1:0]                      req_in,
    input  logic [NREQ-1:0][MATRIX_REG_BITS:0]   req_addr_in,
    output logic [NREQ-1:0]                      grant_out,
    output logic [NREQ-1:0]                      done_out,
    output logic [NREQ-1:0]                      error_out,
    output logic                                 busy_out,
    output logic                                 store_en_out,
    output logic [MATRIX_REG_BITS:0]             store_addr_out,
    input  logic                                 eng_active_in
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = MATRIX_REG_BITS + 1;
    localparam logic [TBITS-1:0] TLAST = TBITS'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TBITS-1:0]  timer_q, timer_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              busy_q, busy_d;
    logic              en_q, en_d;
    logic [AW-1:0]     addr_q, addr_d;

    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [NREQ-1:0]   pick_oh;
    logic [NREQ-1:0]   owner_oh;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i   (req_in),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        pick_oh            = '0;
        pick_oh[pick_idx]  = 1'b1;
        owner_oh           = '0;
        owner_oh[owner_q]  = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        timer_d  = timer_q;
        grant_d  = grant_q;
        done_d   = '0;
        err_d    = '0;
        en_d     = en_q;
        addr_d   = addr_q;

        case (state_q)
            ARB_IDLE: begin
                grant_d = '0;
                en_d    = 1'b0;
                if (pick_found) begin
                    state_d = ARB_START;
                    owner_d = pick_idx;
                    grant_d = pick_oh;
                    en_d    = 1'b1;
                    addr_d  = req_addr_in[pick_idx];
                    timer_d = '0;
                end
            end
            ARB_START: begin
                timer_d = timer_q + TBITS'(1);
                if (timer_q == TLAST) begin
                    state_d = ARB_ERR;
                    en_d    = 1'b0;
                    err_d   = owner_oh;
                end else if (eng_active_in) begin
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                timer_d = timer_q + TBITS'(1);
                // Completion takes priority over a coincident timeout.
                if (!eng_active_in) begin
                    state_d = ARB_DONE;
                    en_d    = 1'b0;
                    done_d  = owner_oh;
                end else if (timer_q == TLAST) begin
                    state_d = ARB_ERR;
                    en_d    = 1'b0;
                    err_d   = owner_oh;
                end
            end
            ARB_DONE, ARB_ERR: begin
                state_d  = ARB_IDLE;
                grant_d  = '0;
                rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                en_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            timer_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            en_q     <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            timer_q  <= timer_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
        end
    end

    assign grant_out      = grant_q;
    assign done_out       = done_q;
    assign error_out      = err_q;
    assign busy_out       = busy_q;
    assign store_en_out   = en_q;
    assign store_addr_out = addr_q;
endmodule

// File: tb/tb_mpu_store_arbiter.sv
// Scoreboarded bench: a phase model predicts the round-robin service order; a monitor checks each grant.
module tb_mpu_store_arbiter;
    import global_defs::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int AW      = MATRIX_REG_BITS + 1;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NREQ-1:0]           req = '0;
    logic [NREQ-1:0][AW-1:0]   req_addr = '0;
    logic [NREQ-1:0]           grant_out, done_out, error_out;
    logic                      busy_out, store_en_out;
    logic [AW-1:0]             store_addr_out;
    logic                      eng_active;

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        bit            err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   dead_req [NREQ];
    int   m_ptr    = 0;
    int   cyc      = 0;
    int   e_fix_wait = 0;
    int   e_fix_len  = 0;

    mpu_store_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_in         (req),
        .req_addr_in    (req_addr),
        .grant_out      (grant_out),
        .done_out       (done_out),
        .error_out      (error_out),
        .busy_out       (busy_out),
        .store_en_out   (store_en_out),
        .store_addr_out (store_addr_out),
        .eng_active_in  (eng_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req_v);
        chk(name, act === req_v, act, req_v);
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Store engine: after enable rises, wait a few cycles, stream for a burst, then drop active.
    bit e_arm, e_dead;
    int e_wait, e_len;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_active <= 1'b0;
            e_arm      <= 1'b0;
            e_dead     <= 1'b0;
            e_wait     <= 0;
            e_len      <= 0;
        end else if (!store_en_out) begin
            eng_active <= 1'b0;
            e_arm      <= 1'b0;
            e_wait     <= 0;
        end else if (!e_arm) begin
            e_arm  <= 1'b1;
            e_dead <= dead_req[oh_idx(grant_out)];
            e_wait <= (e_fix_wait > 0) ? e_fix_wait : int'($urandom_range(1, 3));
            e_len  <= (e_fix_len > 0) ? e_fix_len : int'($urandom_range(1, 9));
        end else if (!e_dead) begin
            if (e_wait > 0) begin
                e_wait <= e_wait - 1;
                if (e_wait == 1) eng_active <= 1'b1;
            end else if (eng_active) begin
                if (e_len <= 1) eng_active <= 1'b0;
                else e_len <= e_len - 1;
            end
        end
    end

    // Monitor: pops the expected transaction at each new grant and checks it through to its pulse.
    bit              cur_valid = 0;
    bit              pend_idle = 0;
    exp_t            cur;
    int              grant_cyc = 0;
    int              en_low_run = 2;
    logic [NREQ-1:0] prev_grant = '0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            cur_valid  = 0;
            pend_idle  = 0;
            prev_grant = '0;
            en_low_run = 2;
        end else begin
            if (pend_idle) begin
                chk_eq("grant_clear_after_pulse", 32'(grant_out), 32'(0));
                chk_eq("busy_clear_after_pulse", 32'(busy_out), 32'(0));
                pend_idle = 0;
            end
            if (prev_grant == '0 && grant_out != '0) begin
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_grant", 32'(grant_out), 32'(0));
                end else begin
                    cur       = exp_q.pop_front();
                    cur_valid = 1;
                    grant_cyc = cyc;
                    chk_eq("grant_owner", 32'(grant_out), 32'(oh(cur.idx)));
                    chk_eq("store_addr", 32'(store_addr_out), 32'(cur.addr));
                    chk_eq("store_en_on_grant", 32'(store_en_out), 32'(1));
                    chk_eq("busy_on_grant", 32'(busy_out), 32'(1));
                    chk("idle_gap_before_grant", en_low_run >= 2, 32'(en_low_run), 32'(2));
                end
            end else if (cur_valid && (done_out | error_out) == '0) begin
                chk_eq("grant_held", 32'(grant_out), 32'(oh(cur.idx)));
                chk_eq("store_en_held", 32'(store_en_out), 32'(1));
            end
            if ((done_out | error_out) != '0) begin
                if (!cur_valid) begin
                    chk_eq("unexpected_pulse", 32'(done_out | error_out), 32'(0));
                end else begin
                    chk_eq("done_pulse", 32'(done_out), cur.err ? 32'(0) : 32'(oh(cur.idx)));
                    chk_eq("error_pulse", 32'(error_out), cur.err ? 32'(oh(cur.idx)) : 32'(0));
                    chk_eq("store_en_low_at_pulse", 32'(store_en_out), 32'(0));
                    chk_eq("grant_at_pulse", 32'(grant_out), 32'(oh(cur.idx)));
                    if (cur.err) chk_eq("timeout_cycles", 32'(cyc - grant_cyc), 32'(TIMEOUT));
                    cur_valid = 0;
                    pend_idle = 1;
                end
            end
            en_low_run = store_en_out ? 0 : en_low_run + 1;
            prev_grant = grant_out;
        end
    end

    // Phase: a set of requests raised together and held until each is answered.
    // The model serves set bits in order from its own pointer, wrapping, one at a time.
    task automatic run_phase(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] dead, input bit drop_early);
        int              last = 0;
        int              budget = 0;
        bit              have_first = 0;
        logic [NREQ-1:0] first_oh = '0;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
                req_addr[i] = AW'($urandom_range(0, (1 << AW) - 1));
                dead_req[i] = dead[i];
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (mask[j]) begin
                exp_q.push_back('{idx: j, addr: req_addr[j], err: dead[j]});
                if (!have_first) begin
                    first_oh   = oh(j);
                    have_first = 1;
                end
                last = j;
            end
        end
        m_ptr = (last + 1) % NREQ;
        req   = mask;
        @(posedge clk); #2;
        chk_eq("grant_latency", 32'(grant_out), 32'(first_oh));
        while (!(req == '0 && !busy_out) && budget < 400) begin
            if ((done_out | error_out) != '0) req = req & ~(done_out | error_out);
            if (drop_early && eng_active && grant_out != '0) req = req & ~grant_out;
            if (grant_out != '0) req_addr[oh_idx(grant_out)] = AW'($urandom_range(0, (1 << AW) - 1));
            @(posedge clk); #2;
            budget++;
        end
        chk("phase_complete", budget < 400, 32'(budget), 32'(400));
        chk_eq("queue_drained", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int b;
        for (int i = 0; i < NREQ; i++) dead_req[i] = 0;
        #1 rst = 1'b1;
        #20;
        chk_eq("reset_grant", 32'(grant_out), 32'(0));
        chk_eq("reset_done", 32'(done_out), 32'(0));
        chk_eq("reset_error", 32'(error_out), 32'(0));
        chk_eq("reset_busy", 32'(busy_out), 32'(0));
        chk_eq("reset_store_en", 32'(store_en_out), 32'(0));
        chk_eq("reset_store_addr", 32'(store_addr_out), 32'(0));
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);

        run_phase(4'b1111, 4'b0000, 0);          // contention from pointer 0: 0,1,2,3
        e_fix_wait = 1;
        e_fix_len  = 9;
        run_phase(4'b0010, 4'b0000, 0);          // single 3x3 store
        e_fix_wait = 0;
        e_fix_len  = 0;
        run_phase(4'b0100, 4'b0000, 0);          // pointer moves to 3
        run_phase(4'b1001, 4'b0000, 0);          // wrap: 3 then 0
        run_phase(4'b0011, 4'b0010, 0);          // 1 times out, 0 served normally
        run_phase(4'b0100, 4'b0000, 1);          // owner drops request mid-transfer

        // Asynchronous reset in the middle of a stream
        run_phase(4'b0010, 4'b0000, 0);
        @(negedge clk);
        req_addr[2] = AW'(5);
        dead_req[2] = 0;
        exp_q.push_back('{idx: 2, addr: AW'(5), err: 1'b0});
        req = 4'b0100;
        b = 0;
        while (!eng_active && b < 50) begin
            @(posedge clk); #2;
            b++;
        end
        chk("engine_started", b < 50, 32'(b), 32'(50));
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk_eq("async_rst_store_en", 32'(store_en_out), 32'(0));
        chk_eq("async_rst_grant", 32'(grant_out), 32'(0));
        chk_eq("async_rst_busy", 32'(busy_out), 32'(0));
        exp_q.delete();
        m_ptr = 0;
        req   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        run_phase(4'b0101, 4'b0000, 0);          // pointer back at 0: 0 before 2
        run_phase(4'b0100, 4'b0000, 0);

        for (int p = 0; p < 30; p++) begin
            logic [NREQ-1:0] m, d;
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            d = '0;
            for (int i = 0; i < NREQ; i++) d[i] = ($urandom_range(0, 5) == 0);
            run_phase(m, d, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
